// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU memory-ordering sequencer: word type, burst payload and FSM states.
package hs_npu_pkg;

  localparam int unsigned UWORD_W         = 32;
  localparam int unsigned MEM_BURST_WORDS = 2;

  typedef logic [UWORD_W-1:0] uword;

  // word0 sits in the upper half so a pair reads naturally as {word0, word1}
  typedef struct packed {
    uword w0;
    uword w1;
  } burst_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_DRAIN,
    S_WR_FILL,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_DRAIN_ABORT
  } ord_state_e;

endpackage

// File: rtl/hs_npu_burst_pack.sv
// Two-slot burst buffer: unpacks a read pair word by word, or packs write words into a pair.
module hs_npu_burst_pack
  import hs_npu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   load,
  input  burst_t load_data,
  input  logic   push,
  input  uword   push_data,
  input  logic   pop,
  output uword   head,
  output burst_t pair,
  output logic   slot,
  output logic   full,
  output logic   empty
);

  burst_t data_q;
  logic   slot_q;
  logic   full_q;
  logic   empty_q;

  // Load has priority over push/pop; push and pop advance the shared slot pointer
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q  <= '0;
      slot_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (load) begin
      data_q  <= load_data;
      slot_q  <= 1'b0;
      full_q  <= 1'b1;
      empty_q <= 1'b0;
    end else if (push && !full_q) begin
      if (slot_q) data_q.w1 <= push_data;
      else        data_q.w0 <= push_data;
      slot_q  <= ~slot_q;
      full_q  <= slot_q;
      empty_q <= 1'b0;
    end else if (pop && !empty_q) begin
      slot_q  <= ~slot_q;
      empty_q <= slot_q;
      full_q  <= full_q & ~slot_q;
    end
  end

  assign head  = slot_q ? data_q.w1 : data_q.w0;
  assign pair  = data_q;
  assign slot  = slot_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/hs_npu_memory_ordering.sv
// Command sequencer ahead of hs_npu_memory_interface: splits a transfer into 2-word bursts,
// unpacks read pairs to a word stream, packs write words into pairs, and drains cleanly on abort.
module hs_npu_memory_ordering
  import hs_npu_pkg::*;
#(
  parameter int unsigned BURST_WORDS = MEM_BURST_WORDS,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned ADDR_STRIDE = BURST_WORDS * 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [31:0]              cmd_addr_i,
  input  logic [LEN_W-1:0]         cmd_bursts_i,
  input  logic                     abort_i,
  output logic                     done_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [31:0]              rd_data_o,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [31:0]              wr_data_i,
  input  logic                     mem_ready_i,
  input  logic                     mem_valid_i,
  output logic                     mem_read_ready_o,
  output logic                     mem_write_valid_o,
  output logic                     mem_invalidate_o,
  input  logic [32*BURST_WORDS-1:0] memory_data_in_i,
  output logic [32*BURST_WORDS-1:0] memory_data_out_o,
  output logic [31:0]              request_address_o
);

  localparam uword STRIDE = uword'(ADDR_STRIDE);

  ord_state_e       state_q, state_d;
  uword             addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             inval_q, inval_d;
  logic             abort_pend_q, abort_pend_d;

  logic   buf_clr, buf_load, buf_push, buf_pop;
  uword   buf_head;
  burst_t buf_pair;
  logic   buf_slot, buf_full, buf_empty;

  logic rd_req_c, wr_req_c, wr_ready_c, rd_valid_c, drop_c;

  hs_npu_burst_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .load      (buf_load),
    .load_data (burst_t'(memory_data_in_i)),
    .push      (buf_push),
    .push_data (wr_data_i),
    .pop       (buf_pop),
    .head      (buf_head),
    .pair      (buf_pair),
    .slot      (buf_slot),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      done_q       <= 1'b0;
      inval_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      done_q       <= done_d;
      inval_q      <= inval_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Next-state, buffer control and handshake strobes
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    done_d       = 1'b0;
    inval_d      = 1'b0;
    abort_pend_d = abort_pend_q;
    buf_clr      = 1'b0;
    buf_load     = 1'b0;
    buf_push     = 1'b0;
    buf_pop      = 1'b0;
    rd_req_c     = 1'b0;
    wr_req_c     = 1'b0;
    wr_ready_c   = 1'b0;
    rd_valid_c   = 1'b0;
    drop_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (abort_i) begin
          drop_c = 1'b1;
        end else if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          rem_d   = cmd_bursts_i;
          buf_clr = 1'b1;
          if (cmd_bursts_i == '0) done_d  = 1'b1;
          else if (cmd_write_i)   state_d = S_WR_FILL;
          else                    state_d = S_RD_ISSUE;
        end
      end

      S_RD_ISSUE: begin
        if (abort_i) begin
          drop_c = 1'b1;
        end else begin
          rd_req_c = 1'b1;
          if (mem_ready_i) state_d = S_RD_WAIT;
        end
      end

      // rready drops in the data cycle so the interface does not restart a read from idle
      S_RD_WAIT: begin
        rd_req_c = ~mem_valid_i & ~abort_i;
        if (mem_valid_i) begin
          if (abort_i) begin
            drop_c = 1'b1;
          end else begin
            buf_load = 1'b1;
            addr_d   = addr_q + STRIDE;
            rem_d    = rem_q - LEN_W'(1);
            state_d  = S_RD_DRAIN;
          end
        end else if (abort_i) begin
          inval_d = 1'b1;
          state_d = S_DRAIN_ABORT;
        end
      end

      S_RD_DRAIN: begin
        rd_valid_c = ~buf_empty;
        if (abort_i) begin
          drop_c = 1'b1;
        end else if (rd_ready_i && !buf_empty) begin
          buf_pop = 1'b1;
          if (buf_slot) begin
            if (rem_q == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_ISSUE;
            end
          end
        end
      end

      S_DRAIN_ABORT: begin
        if (mem_valid_i) drop_c = 1'b1;
      end

      S_WR_FILL: begin
        wr_ready_c = ~buf_full;
        if (abort_i) begin
          drop_c = 1'b1;
        end else if (wr_valid_i && !buf_full) begin
          buf_push = 1'b1;
          if (buf_slot) state_d = S_WR_ISSUE;
        end
      end

      S_WR_ISSUE: begin
        abort_pend_d = abort_pend_q | abort_i;
        wr_req_c     = mem_ready_i;
        if (mem_ready_i) state_d = S_WR_WAIT;
      end

      // An abort seen during the write is honoured only once the write completes
      S_WR_WAIT: begin
        abort_pend_d = abort_pend_q | abort_i;
        if (mem_ready_i) begin
          addr_d  = addr_q + STRIDE;
          rem_d   = rem_q - LEN_W'(1);
          buf_clr = 1'b1;
          if (abort_pend_d) begin
            drop_c = 1'b1;
          end else if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WR_FILL;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (drop_c) begin
      state_d      = S_IDLE;
      done_d       = 1'b1;
      buf_clr      = 1'b1;
      rem_d        = '0;
      abort_pend_d = 1'b0;
    end
  end

  assign cmd_ready_o       = (state_q == S_IDLE);
  assign done_o            = done_q;
  assign mem_invalidate_o  = inval_q;
  assign request_address_o = addr_q;
  assign rd_valid_o        = rd_valid_c;
  assign rd_data_o         = buf_head;
  assign wr_ready_o        = wr_ready_c;
  assign mem_read_ready_o  = rd_req_c;
  assign mem_write_valid_o = wr_req_c;
  assign memory_data_out_o = buf_pair;

endmodule

// File: tb/tb_hs_npu_memory_ordering.sv
// Directed bench for hs_npu_memory_ordering with a small interface responder model.
module tb_hs_npu_memory_ordering;
  import hs_npu_pkg::*;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0]      cmd_addr_i;
  logic [LEN_W-1:0] cmd_bursts_i;
  logic             abort_i, done_o;
  logic             rd_valid_o, rd_ready_i;
  logic [31:0]      rd_data_o;
  logic             wr_valid_i, wr_ready_o;
  logic [31:0]      wr_data_i;
  logic             mem_ready_i, mem_valid_i;
  logic             mem_read_ready_o, mem_write_valid_o, mem_invalidate_o;
  logic [63:0]      memory_data_in_i, memory_data_out_o;
  logic [31:0]      request_address_o;

  hs_npu_memory_ordering #(.BURST_WORDS(2), .LEN_W(LEN_W), .ADDR_STRIDE(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_bursts_i(cmd_bursts_i),
    .abort_i(abort_i), .done_o(done_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
    .mem_read_ready_o(mem_read_ready_o), .mem_write_valid_o(mem_write_valid_o),
    .mem_invalidate_o(mem_invalidate_o),
    .memory_data_in_i(memory_data_in_i), .memory_data_out_o(memory_data_out_o),
    .request_address_o(request_address_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int   done_cnt, inv_cnt, rdv_cnt, wrv_cnt;
  bit   rd_returned;
  uword rd_word_q[$];
  uword rd_addr_q[$];
  uword wr_addr_q[$];
  logic [63:0] wr_data_q[$];

  function automatic uword pat(input uword a);
    return a + 32'h1000_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    done_cnt = 0; inv_cnt = 0; rdv_cnt = 0; wrv_cnt = 0; rd_returned = 1'b0;
    rd_word_q.delete(); rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
  endtask

  // Interface responder: read returns a pair 4 cycles after handshake, write completes 3 cycles after issue
  initial begin
    int   rd_cnt, wr_cnt;
    uword rd_addr;
    logic s_rrdy, s_wval, s_rdy, s_rst;
    uword s_addr;
    logic [63:0] s_wdata;
    rd_cnt = 0; wr_cnt = 0; rd_addr = '0;
    mem_ready_i = 1'b1; mem_valid_i = 1'b0; memory_data_in_i = '0;
    forever begin
      @(posedge clk);
      s_rrdy = mem_read_ready_o; s_wval = mem_write_valid_o; s_rdy = mem_ready_i;
      s_rst = rst; s_addr = request_address_o; s_wdata = memory_data_out_o;
      #1;
      mem_valid_i = 1'b0;
      if (s_rst) begin
        mem_ready_i = 1'b1; rd_cnt = 0; wr_cnt = 0;
      end else if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_valid_i = 1'b1;
          memory_data_in_i = {pat(rd_addr), pat(rd_addr + 32'd4)};
          mem_ready_i = 1'b1;
          rd_returned = 1'b1;
        end
      end else if (wr_cnt != 0) begin
        wr_cnt--;
        if (wr_cnt == 0) mem_ready_i = 1'b1;
      end else if (s_rdy && s_rrdy) begin
        rd_cnt = 4; rd_addr = s_addr; mem_ready_i = 1'b0;
        rd_addr_q.push_back(s_addr);
      end else if (s_rdy && s_wval) begin
        wr_cnt = 3; mem_ready_i = 1'b0;
        wr_addr_q.push_back(s_addr);
        wr_data_q.push_back(s_wdata);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (done_o) done_cnt++;
        if (mem_invalidate_o) inv_cnt++;
        if (rd_valid_o) rdv_cnt++;
        if (rd_valid_o && rd_ready_i) rd_word_q.push_back(rd_data_o);
        if (mem_write_valid_o) wrv_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset(input string tag);
    chk({tag, " cmd_ready"},   64'(cmd_ready_o), 64'(1));
    chk({tag, " done"},        64'(done_o), 64'(0));
    chk({tag, " rd_valid"},    64'(rd_valid_o), 64'(0));
    chk({tag, " rd_data"},     64'(rd_data_o), 64'(0));
    chk({tag, " wr_ready"},    64'(wr_ready_o), 64'(0));
    chk({tag, " rready"},      64'(mem_read_ready_o), 64'(0));
    chk({tag, " wvalid"},      64'(mem_write_valid_o), 64'(0));
    chk({tag, " invalidate"},  64'(mem_invalidate_o), 64'(0));
    chk({tag, " wdata"},       memory_data_out_o, 64'(0));
    chk({tag, " req_addr"},    64'(request_address_o), 64'(0));
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 64'(seen), 64'(1));
    tick();
    tick();
  endtask

  task automatic issue(input logic wr, input uword addr, input logic [15:0] bursts);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_bursts_i = bursts;
    tick();
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
  endtask

  // Issue a command and, for writes, stream words wbase, wbase+1, ... until done
  task automatic run_cmd(input logic wr, input uword addr, input logic [15:0] bursts,
                         input uword wbase, output bit finished);
    int sent;
    bit acc;
    sent = 0; finished = 1'b0;
    issue(wr, addr, bursts);
    for (int c = 0; c < 400; c++) begin
      if (done_o) begin
        finished = 1'b1;
        break;
      end
      if (wr && sent < 2 * int'(bursts)) begin
        wr_valid_i = 1'b1;
        wr_data_i  = wbase + uword'(sent);
      end else begin
        wr_valid_i = 1'b0;
      end
      acc = wr_valid_i && wr_ready_o;
      tick();
      if (acc) sent++;
    end
    wr_valid_i = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic        wr;
    uword        addr;
    logic [15:0] bursts;
    uword        wbase;
    uword        exp_last;
    uword        exp_end;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit fin;
    vecs[0] = '{wr: 1'b0, addr: 32'h0000_0100, bursts: 16'd3, wbase: 32'h0,         exp_last: 32'h0000_0110, exp_end: 32'h0000_0118};
    vecs[1] = '{wr: 1'b1, addr: 32'h0000_0200, bursts: 16'd2, wbase: 32'hA000_0000, exp_last: 32'h0000_0208, exp_end: 32'h0000_0210};
    vecs[2] = '{wr: 1'b0, addr: 32'hFFFF_FFF8, bursts: 16'd2, wbase: 32'h0,         exp_last: 32'h0000_0000, exp_end: 32'h0000_0008};
    vecs[3] = '{wr: 1'b1, addr: 32'h0000_0040, bursts: 16'd1, wbase: 32'hC0DE_0000, exp_last: 32'h0000_0040, exp_end: 32'h0000_0048};
    vecs[4] = '{wr: 1'b0, addr: 32'h0000_0300, bursts: 16'd0, wbase: 32'h0,         exp_last: 32'h0000_0000, exp_end: 32'h0000_0300};

    rst = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_bursts_i = '0;
    abort_i = 1'b0; rd_ready_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = '0;
    clear_logs();
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      clear_logs();
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].bursts, vecs[i].wbase, fin);
      chk($sformatf("v%0d finished", i), 64'(fin), 64'(1));
      chk($sformatf("v%0d done pulses", i), 64'(done_cnt), 64'(1));
      chk($sformatf("v%0d end addr", i), 64'(request_address_o), 64'(vecs[i].exp_end));
      chk($sformatf("v%0d cmd_ready", i), 64'(cmd_ready_o), 64'(1));
      if (vecs[i].wr) begin
        chk($sformatf("v%0d wr reqs", i), 64'(wr_addr_q.size()), 64'(vecs[i].bursts));
        chk($sformatf("v%0d wvalid cycles", i), 64'(wrv_cnt), 64'(vecs[i].bursts));
        chk($sformatf("v%0d rd reqs", i), 64'(rd_addr_q.size()), 64'(0));
        for (int k = 0; k < wr_addr_q.size(); k++) begin
          chk($sformatf("v%0d wr addr %0d", i, k), 64'(wr_addr_q[k]), 64'(vecs[i].addr + uword'(8 * k)));
          chk($sformatf("v%0d wr data %0d", i, k), wr_data_q[k],
              {vecs[i].wbase + uword'(2 * k), vecs[i].wbase + uword'(2 * k + 1)});
        end
        if (wr_addr_q.size() != 0)
          chk($sformatf("v%0d last addr", i), 64'(wr_addr_q[wr_addr_q.size()-1]), 64'(vecs[i].exp_last));
      end else begin
        chk($sformatf("v%0d rd reqs", i), 64'(rd_addr_q.size()), 64'(vecs[i].bursts));
        chk($sformatf("v%0d wr reqs", i), 64'(wr_addr_q.size()), 64'(0));
        chk($sformatf("v%0d word count", i), 64'(rd_word_q.size()), 64'(2 * int'(vecs[i].bursts)));
        for (int k = 0; k < rd_word_q.size(); k++)
          chk($sformatf("v%0d word %0d", i, k), 64'(rd_word_q[k]), 64'(pat(vecs[i].addr + uword'(4 * k))));
        if (rd_addr_q.size() != 0)
          chk($sformatf("v%0d last addr", i), 64'(rd_addr_q[rd_addr_q.size()-1]), 64'(vecs[i].exp_last));
      end
    end

    // Zero-burst command: done the cycle after acceptance, no memory traffic
    clear_logs();
    issue(1'b1, 32'h0000_0800, 16'd0);
    chk("zero done pulse", 64'(done_o), 64'(1));
    chk("zero cmd_ready", 64'(cmd_ready_o), 64'(1));
    tick();
    chk("zero done clears", 64'(done_o), 64'(0));
    tick();
    chk("zero no requests", 64'(rd_addr_q.size() + wr_addr_q.size()), 64'(0));
    chk("zero addr latched", 64'(request_address_o), 64'h800);

    // Backpressure: stall the consumer with word1 of the first burst pending
    clear_logs();
    rd_ready_i = 1'b0;
    issue(1'b0, 32'h0000_0400, 16'd2);
    for (int c = 0; c < 50; c++) begin
      if (rd_valid_o) break;
      tick();
    end
    chk("bp first word", 64'(rd_data_o), 64'(pat(32'h400)));
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp hold %0d", c), 64'({mem_read_ready_o, rd_valid_o, rd_data_o}),
          64'({1'b0, 1'b1, pat(32'h404)}));
      tick();
    end
    rd_ready_i = 1'b1;
    wait_done("bp done");
    chk("bp word count", 64'(rd_word_q.size()), 64'(4));
    for (int k = 0; k < rd_word_q.size(); k++)
      chk($sformatf("bp word %0d", k), 64'(rd_word_q[k]), 64'(pat(32'h400 + uword'(4 * k))));
    chk("bp rd reqs", 64'(rd_addr_q.size()), 64'(2));
    chk("bp done pulses", 64'(done_cnt), 64'(1));

    // Abort while the read is in flight
    clear_logs();
    issue(1'b0, 32'h0000_0500, 16'd2);
    for (int c = 0; c < 50; c++) begin
      if (!mem_ready_i && mem_read_ready_o) break;
      tick();
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort invalidate high", 64'(mem_invalidate_o), 64'(1));
    chk("abort no early done", 64'(done_o), 64'(0));
    tick();
    chk("abort invalidate low", 64'(mem_invalidate_o), 64'(0));
    for (int c = 0; c < 50; c++) begin
      if (done_o) break;
      tick();
    end
    chk("abort done after data", 64'({done_o, rd_returned}), 64'({1'b1, 1'b1}));
    tick();
    tick();
    chk("abort invalidate count", 64'(inv_cnt), 64'(1));
    chk("abort rd_valid never", 64'(rdv_cnt), 64'(0));
    chk("abort done pulses", 64'(done_cnt), 64'(1));
    chk("abort rd reqs", 64'(rd_addr_q.size()), 64'(1));
    chk("abort idle", 64'(cmd_ready_o), 64'(1));

    // Command presented while busy is ignored
    clear_logs();
    issue(1'b0, 32'h0000_0600, 16'd1);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h0000_0900; cmd_bursts_i = 16'd5;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("busy hold %0d", c), 64'({cmd_ready_o, request_address_o}), 64'({1'b0, 32'h600}));
      tick();
    end
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
    wait_done("busy done");
    chk("busy rd reqs", 64'(rd_addr_q.size()), 64'(1));
    if (rd_addr_q.size() != 0) chk("busy rd addr", 64'(rd_addr_q[0]), 64'h600);
    chk("busy wr reqs", 64'(wr_addr_q.size()), 64'(0));
    chk("busy words", 64'(rd_word_q.size()), 64'(2));
    chk("busy done pulses", 64'(done_cnt), 64'(1));

    // Reset in the middle of a write command
    clear_logs();
    begin
      int sent;
      bit acc;
      sent = 0;
      issue(1'b1, 32'h0000_0700, 16'd2);
      for (int c = 0; c < 100 && sent < 3; c++) begin
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hBEEF_0000 + uword'(sent);
        acc = wr_ready_o;
        tick();
        if (acc) sent++;
      end
      wr_valid_i = 1'b0;
      chk("midwrite words sent", 64'(sent), 64'(3));
    end
    tick();
    chk("midwrite busy", 64'(cmd_ready_o), 64'(0));
    rst = 1'b1;
    tick();
    check_reset("midwrite rst");
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
